// File: rtl/srl_fifo.sv
// ============================================================================
//  Module   : srl_fifo
//  Brief    : Elastic FIFO built from a tapped shift-register store with a
//             registered valid/ready output stage. Capacity is DEPTH + 1.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module srl_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int LBITS = $clog2(DEPTH + 2)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] data_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] data_o,
    output logic [LBITS-1:0] level_o
);

    localparam int c_cbits = $clog2(DEPTH + 1);
    localparam int c_abits = $clog2(DEPTH);

    logic [WIDTH-1:0]   r_srl [DEPTH];
    logic [c_cbits-1:0] r_count;
    logic               r_valid;
    logic               r_ready;
    logic [WIDTH-1:0]   r_data;

    logic               w_write;
    logic               w_load;
    logic               w_empty;
    logic               w_shift;
    logic               w_pop;
    logic [c_abits-1:0] w_addr;
    logic [c_cbits-1:0] w_count_next;

    assign w_write = valid_i && r_ready;
    assign w_load  = !r_valid || ready_i;
    assign w_empty = (r_count == '0);
    // An empty store with a free output register bypasses straight to data_o.
    assign w_shift = w_write && !(w_load && w_empty);
    assign w_pop   = w_load && !w_empty;
    assign w_addr  = c_abits'(r_count - c_cbits'(1));

    assign w_count_next = r_count + c_cbits'(w_shift) - c_cbits'(w_pop);

    // Store carries no reset so it maps onto shift-register LUTs.
    always_ff @(posedge clock) begin
        if (w_shift) begin
            for (int i = DEPTH - 1; i > 0; i--) begin
                r_srl[i] <= r_srl[i-1];
            end
            r_srl[0] <= data_i;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_count <= '0;
            r_ready <= 1'b0;
        end else begin
            r_count <= w_count_next;
            r_ready <= (w_count_next < c_cbits'(DEPTH));
        end
    end

    // Tap read uses the pre-shift array, so a simultaneous shift cannot reorder.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (w_load) begin
            if (!w_empty) begin
                r_data  <= r_srl[w_addr];
                r_valid <= 1'b1;
            end else if (w_write) begin
                r_data  <= data_i;
                r_valid <= 1'b1;
            end else begin
                r_valid <= 1'b0;
            end
        end
    end

    assign ready_o = r_ready;
    assign valid_o = r_valid;
    assign data_o  = r_data;
    assign level_o = LBITS'(r_count) + LBITS'(r_valid);

endmodule

`default_nettype wire

// File: tb/tb_srl_fifo.sv
// ============================================================================
//  Module   : tb_srl_fifo
//  Brief    : Scoreboard testbench for srl_fifo with directed vectors.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_srl_fifo;

    localparam int WIDTH = 8;
    localparam int DEPTH = 16;
    localparam int LBITS = $clog2(DEPTH + 2);

    logic             clock   = 1'b0;
    logic             reset   = 1'b1;
    logic             valid_i = 1'b0;
    logic [WIDTH-1:0] data_i  = '0;
    logic             ready_i = 1'b0;
    logic             ready_o;
    logic             valid_o;
    logic [WIDTH-1:0] data_o;
    logic [LBITS-1:0] level_o;

    logic [WIDTH-1:0] sb [$];
    int n_cmp = 0;
    int n_err = 0;

    srl_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clock   (clock),
        .reset   (reset),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .data_i  (data_i),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .data_o  (data_o),
        .level_o (level_o)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Input side: every accepted word becomes an expected output.
    always @(negedge clock) begin
        if (!reset && valid_i && ready_o) sb.push_back(data_i);
    end

    // Output side: every handshake pops and compares.
    always @(negedge clock) begin
        if (!reset && valid_o && ready_i) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_output: got %0h, expected no word", data_o);
            end else begin
                check("data_order", 32'(data_o), 32'(sb.pop_front()));
            end
        end
    end

    always @(posedge clock) begin
        #2;
        check("level_vs_scoreboard", 32'(level_o), 32'(sb.size()));
    end

    task automatic apply(input logic v, input logic [WIDTH-1:0] d, input logic r);
        valid_i = v;
        data_i  = d;
        ready_i = r;
        @(posedge clock);
        #1;
    endtask

    initial begin
        repeat (3) @(posedge clock);
        #1;
        check("reset_valid", 32'(valid_o), 0);
        check("reset_ready", 32'(ready_o), 0);
        check("reset_data",  32'(data_o),  0);
        check("reset_level", 32'(level_o), 0);

        // Reset release then single word
        reset = 1'b0;
        apply(1'b0, 8'h00, 1'b0);
        check("ready_after_release", 32'(ready_o), 1);
        check("valid_idle", 32'(valid_o), 0);
        apply(1'b1, 8'hA5, 1'b0);
        check("single_valid", 32'(valid_o), 1);
        check("single_data",  32'(data_o),  32'h A5);
        check("single_level", 32'(level_o), 1);
        apply(1'b0, 8'h00, 1'b1);
        check("single_drained", 32'(valid_o), 0);

        // Fill with downstream stalled
        for (int i = 0; i < DEPTH + 1; i++) begin
            check("fill_ready", 32'(ready_o), 1);
            apply(1'b1, 8'(i), 1'b0);
        end
        check("full_ready", 32'(ready_o), 0);
        check("full_level", 32'(level_o), 17);
        apply(1'b1, 8'h11, 1'b0);
        check("full_reject_ready", 32'(ready_o), 0);
        check("full_reject_level", 32'(level_o), 17);
        check("full_head", 32'(data_o), 0);

        // Drain from full
        apply(1'b0, 8'h00, 1'b1);
        check("ready_after_first_pop", 32'(ready_o), 1);
        check("drain_data", 32'(data_o), 1);
        for (int j = 2; j <= DEPTH; j++) begin
            apply(1'b0, 8'h00, 1'b1);
            check("drain_data", 32'(data_o), 32'(j));
        end
        apply(1'b0, 8'h00, 1'b1);
        check("drain_valid", 32'(valid_o), 0);
        check("drain_level", 32'(level_o), 0);

        // Streaming
        for (int i = 0; i < 100; i++) begin
            apply(1'b1, 8'(i), 1'b1);
            check("stream_data",  32'(data_o),  32'(i));
            check("stream_level", 32'(level_o), 1);
            check("stream_ready", 32'(ready_o), 1);
        end
        apply(1'b0, 8'h00, 1'b1);
        check("stream_end_valid", 32'(valid_o), 0);

        // Random stalls
        repeat (10000) apply(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));
        repeat (DEPTH + 2) apply(1'b0, 8'h00, 1'b1);
        check("random_end_level", 32'(level_o), 0);
        check("random_end_sb", 32'(sb.size()), 0);

        // Mid-stream asynchronous reset
        for (int k = 0; k < 5; k++) apply(1'b1, 8'(8'h50 + k), 1'b0);
        check("pre_reset_level", 32'(level_o), 5);
        valid_i = 1'b0;
        #2;
        reset = 1'b1;
        sb.delete();
        #1;
        check("async_reset_valid", 32'(valid_o), 0);
        check("async_reset_ready", 32'(ready_o), 0);
        check("async_reset_level", 32'(level_o), 0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        apply(1'b0, 8'h00, 1'b0);
        check("post_reset_ready", 32'(ready_o), 1);
        apply(1'b1, 8'h3C, 1'b0);
        check("post_reset_valid", 32'(valid_o), 1);
        check("post_reset_data",  32'(data_o),  32'h3C);
        check("post_reset_level", 32'(level_o), 1);
        apply(1'b0, 8'h00, 1'b1);
        check("post_reset_no_stale", 32'(valid_o), 0);
        check("post_reset_level0", 32'(level_o), 0);
        check("final_sb_empty", 32'(sb.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
